// File: rtl/serial_word_feeder_if.sv
// serial_word_feeder_if
//   Bundles the word-load handshake and the serial bit stream of the
//   serial_word_feeder.
//   master : word producer / serial consumer (drives load_*, stall)
//   slave  : the feeder itself (drives load_ready and the serial outputs)
//   Signals:
//     load_valid  - load_data is presented
//     load_data   - WIDTH-bit word, MSB is sent first
//     load_ready  - feeder can accept a word this cycle
//     stall       - downstream hold request, freezes the shifter
//     bit_out     - current serial bit
//     bit_valid   - bit_out is a real frame bit this cycle
//     frame_start - current valid bit is the frame MSB
//     frame_end   - current valid bit is the frame LSB
//     busy        - a frame is in progress
interface serial_word_feeder_if #(
  parameter int WIDTH = 10
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             stall;
  logic             bit_out;
  logic             bit_valid;
  logic             frame_start;
  logic             frame_end;
  logic             busy;

  modport master (
    output load_valid, load_data, stall,
    input  load_ready, bit_out, bit_valid, frame_start, frame_end, busy
  );

  modport slave (
    input  load_valid, load_data, stall,
    output load_ready, bit_out, bit_valid, frame_start, frame_end, busy
  );
endinterface

// File: rtl/serial_word_feeder.sv
// serial_word_feeder
//   Parallel-to-serial front end for the serial pattern detector. Accepts a
//   WIDTH-bit word over a valid/ready handshake and shifts it out MSB first,
//   one bit per unstalled clock, with first/last-bit frame markers.
//   Ports:
//     clock - rising-edge clock
//     reset - asynchronous, active-high; clears all state immediately
//     sif   - serial_word_feeder_if.slave (load handshake, stall, serial out)
//   A new word can be accepted in the same cycle as the last bit of the
//   current frame, so back-to-back frames stream with no idle gap.
module serial_word_feeder #(
  parameter int WIDTH = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  serial_word_feeder_if.slave  sif
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic bit_valid;
  logic frame_start;
  logic frame_end;
  logic load_ready;
  logic accept;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;

    // A stalled cycle is not a frame bit, so it also hides frame_end and
    // with it the early load_ready of the last bit.
    bit_valid   = (state == SHIFT) && !sif.stall;
    frame_start = bit_valid && (cnt == CNT_FULL);
    frame_end   = bit_valid && (cnt == CNT_ONE);
    load_ready  = (state == IDLE) || frame_end;
    accept      = sif.load_valid && load_ready;

    if (accept) begin
      sreg_nxt  = sif.load_data;
      cnt_nxt   = CNT_FULL;
      state_nxt = SHIFT;
    end else if (frame_end) begin
      // Shifting out the last bit leaves sreg all zeros, so bit_out idles low.
      sreg_nxt  = {sreg[WIDTH-2:0], 1'b0};
      cnt_nxt   = '0;
      state_nxt = IDLE;
    end else if (bit_valid) begin
      sreg_nxt  = {sreg[WIDTH-2:0], 1'b0};
      cnt_nxt   = cnt - CNT_ONE;
    end
  end

  assign sif.bit_out     = sreg[WIDTH-1];
  assign sif.bit_valid   = bit_valid;
  assign sif.frame_start = frame_start;
  assign sif.frame_end   = frame_end;
  assign sif.busy        = (state == SHIFT);
  assign sif.load_ready  = load_ready;

endmodule
